// File: rtl/btn_sel_decoder.sv
// Push-button to mux-select decoder: per-button sync + debounce, then a small
// FSM that turns exactly-one-pressed into a registered {1'b1, idx} select code.

module btn_sel_lane #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db
);
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Counter only runs while the synced level disagrees with the accepted one,
    // so any glitch back to the old level restarts qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db = r_db;
endmodule

module btn_sel_decoder #(
    parameter int NUM_BTN   = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int STICKY    = 0,
    parameter int IDX_W     = $clog2(NUM_BTN),
    parameter int SEL_W     = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [SEL_W-1:0]   sel_out,
    output logic               sel_valid,
    output logic               press_pulse,
    output logic               multi_err
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_BLOCKED
    } state_t;

    logic [NUM_BTN-1:0] w_db;
    logic [IDX_W-1:0]   w_idx;
    logic [SEL_W-1:0]   w_code;
    logic               w_none;
    logic               w_multi;
    logic               w_one;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_pulse;
    logic               r_err;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
        btn_sel_lane #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .i_raw(btn_in[g]),
            .o_db (w_db[g])
        );
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_none  = (w_db == '0);
    assign w_multi = |(w_db & (w_db - NUM_BTN'(1)));
    assign w_one   = !w_none && !w_multi;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_db[i]) w_idx = IDX_W'(i);
        end
    end

    assign w_code = {1'b1, w_idx};

    // In sticky mode re-pressing the held button reloads the same code, so the
    // strobe is qualified by an actual change of sel_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_pulse <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_one) begin
                        r_state <= S_ACTIVE;
                        r_sel   <= w_code;
                        r_pulse <= (w_code != r_sel);
                    end else if (w_multi) begin
                        r_state <= S_BLOCKED;
                        r_err   <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_none) begin
                        r_state <= S_IDLE;
                        if (STICKY == 0) r_sel <= '0;
                    end else if (w_multi) begin
                        r_state <= S_BLOCKED;
                        r_err   <= 1'b1;
                        if (STICKY == 0) r_sel <= '0;
                    end else if (w_code != r_sel) begin
                        r_sel   <= w_code;
                        r_pulse <= 1'b1;
                    end
                end
                S_BLOCKED: begin
                    if (w_none) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign btn_db      = w_db;
    assign sel_out     = r_sel;
    assign sel_valid   = |r_sel;
    assign press_pulse = r_pulse;
    assign multi_err   = r_err;
endmodule

// File: tb/tb_btn_sel_decoder.sv
// Drives a momentary and a sticky decoder from the same buttons and compares
// both against a window-based debounce model plus a press/lockout rule model.

module tb_btn_sel_decoder;
    localparam int NB = 4;
    localparam int DB = 4;
    localparam int SW = 3;
    localparam int VW = 2 * NB + 2 * (SW + 3);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_in = '0;

    logic [NB-1:0] db0, db1;
    logic [SW-1:0] sel0, sel1;
    logic          v0, v1, p0, p1, e0, e1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_sel_decoder #(.NUM_BTN(NB), .DB_CYCLES(DB), .STICKY(0)) u_mom (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(db0), .sel_out(sel0),
        .sel_valid(v0), .press_pulse(p0), .multi_err(e0)
    );

    btn_sel_decoder #(.NUM_BTN(NB), .DB_CYCLES(DB), .STICKY(1)) u_stk (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(db1), .sel_out(sel1),
        .sel_valid(v1), .press_pulse(p1), .multi_err(e1)
    );

    wire [VW-1:0] w_obs = {db0, db1, sel0, v0, p0, e0, sel1, v1, p1, e1};

    // Reference model state
    logic [NB-1:0] m_s1, m_s2, m_db;
    logic [NB-1:0] m_hist[$];
    bit            m_blk, m_p0, m_p1;
    logic [SW-1:0] m_ns, m_st;

    function automatic logic [VW-1:0] exp_vec();
        return {m_db, m_db, m_ns, |m_ns, m_p0, m_blk, m_st, |m_st, m_p1, m_blk};
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        m_hist.delete();
        m_blk = 0; m_p0 = 0; m_p1 = 0;
        m_ns = '0; m_st = '0;
    endtask

    // Selection rules: lockout set by any multi-press and cleared only by all released;
    // a level is accepted once the last DB synced samples all disagree with it.
    task automatic model_edge();
        int            pop;
        int            idx;
        bit            nb;
        bit            all_diff;
        logic [SW-1:0] nns, nst;
        logic [NB-1:0] ndb;
        if (rst) begin
            model_reset();
            return;
        end
        pop = $countones(m_db);
        idx = 0;
        for (int i = 0; i < NB; i++) if (m_db[i]) idx = i;
        nb  = m_blk ? (pop != 0) : (pop >= 2);
        nns = (pop == 1 && !nb) ? SW'((1 << (SW - 1)) + idx) : '0;
        nst = (nns != 0) ? nns : m_st;
        m_p0 = (nns != 0) && (nns != m_ns);
        m_p1 = (nst != m_st);
        m_ns = nns; m_st = nst; m_blk = nb;

        m_hist.push_back(m_s2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        ndb = m_db;
        for (int i = 0; i < NB; i++) begin
            all_diff = (m_hist.size() == DB);
            foreach (m_hist[k]) if (m_hist[k][i] == m_db[i]) all_diff = 0;
            if (all_diff) ndb[i] = ~m_db[i];
        end
        m_db = ndb;
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1; btn_in = 4'b1111;
        step(); step();
        checks++;
        if (w_obs !== '0) begin
            errors++; $display("FAIL reset_hold obs=%h exp=0", w_obs);
        end
        rst = 1'b0;
        repeat (10) begin
            step();
            pulses += int'(p0) + int'(p1);
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++; $display("FAIL reset_release obs=%h exp=%h", w_obs, exp_vec());
            end
        end
        checks++;
        if (!(e0 === 1'b1 && sel0 === 3'b000 && sel1 === 3'b000 && pulses == 0)) begin
            errors++;
            $display("FAIL reset_multi err=%b sel=%b pulses=%0d exp err=1 sel=000 pulses=0", e0, sel0, pulses);
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        btn_in = '0;
        repeat (12) begin
            step(); checks++;
            if (w_obs !== exp_vec()) begin
                errors++; $display("FAIL single_settle obs=%h exp=%h", w_obs, exp_vec());
            end
        end
        btn_in = 4'b0001;
        for (int e = 0; e < 9; e++) begin
            step(); checks++;
            pulses += int'(p0);
            if (w_obs !== exp_vec()) begin
                errors++; $display("FAIL single_press obs=%h exp=%h", w_obs, exp_vec());
            end
            if (e == 6) begin
                checks++;
                if (!(sel0 === 3'b100 && v0 === 1'b1 && p0 === 1'b1)) begin
                    errors++; $display("FAIL single_edge6 sel=%b v=%b p=%b exp 100 1 1", sel0, v0, p0);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL single_pulses got=%0d exp=1", pulses);
        end
        btn_in = '0;
        repeat (8) begin
            step(); checks++;
            if (w_obs !== exp_vec()) begin
                errors++; $display("FAIL single_release obs=%h exp=%h", w_obs, exp_vec());
            end
        end
        checks++;
        if (!(sel0 === 3'b000 && sel1 === 3'b100)) begin
            errors++; $display("FAIL single_released sel0=%b sel1=%b exp 000 100", sel0, sel1);
        end
    endtask

    task automatic test_bounce();
        int   flips = 0;
        int   pulses = 0;
        logic prev;
        btn_in = '0;
        repeat (12) step();
        prev = db0[2];
        for (int k = 0; k < 18; k++) begin
            btn_in = (k >= 8 || k % 2 == 0) ? 4'b0100 : 4'b0000;
            step(); checks++;
            if (db0[2] !== prev) flips++;
            prev = db0[2];
            pulses += int'(p0);
            if (w_obs !== exp_vec()) begin
                errors++; $display("FAIL bounce obs=%h exp=%h", w_obs, exp_vec());
            end
        end
        checks++;
        if (!(flips == 1 && pulses == 1 && sel0 === 3'b110)) begin
            errors++; $display("FAIL bounce_once flips=%0d pulses=%0d sel=%b exp 1 1 110", flips, pulses, sel0);
        end
    endtask

    task automatic test_multi();
        logic [NB-1:0] seq [5] = '{4'b0000, 4'b1000, 4'b1010, 4'b0010, 4'b0000};
        logic [SW-1:0] xsel[5] = '{3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
        logic          xerr[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 6; s++) begin
            btn_in = (s == 5) ? 4'b0010 : seq[s];
            repeat (10) begin
                step(); checks++;
                if (w_obs !== exp_vec()) begin
                    errors++; $display("FAIL multi_seq%0d obs=%h exp=%h", s, w_obs, exp_vec());
                end
            end
            checks++;
            if (s < 5 && !(sel0 === xsel[s] && e0 === xerr[s])) begin
                errors++; $display("FAIL multi_phase%0d sel=%b err=%b exp %b %b", s, sel0, e0, xsel[s], xerr[s]);
            end else if (s == 5 && sel0 !== 3'b101) begin
                errors++; $display("FAIL multi_accept sel=%b exp=101", sel0);
            end
        end
    endtask

    task automatic test_sticky();
        logic [NB-1:0] seq [6] = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
        logic [SW-1:0] xsel[6] = '{3'b101, 3'b101, 3'b101, 3'b111, 3'b111, 3'b111};
        int            xp  [6] = '{0, 0, 0, 1, 0, 0};
        int            pulses;
        for (int s = 0; s < 6; s++) begin
            btn_in = seq[s];
            pulses = 0;
            repeat (10) begin
                step(); checks++;
                pulses += int'(p1);
                if (w_obs !== exp_vec()) begin
                    errors++; $display("FAIL sticky_seq%0d obs=%h exp=%h", s, w_obs, exp_vec());
                end
            end
            checks++;
            if (s > 0 && !(sel1 === xsel[s] && pulses == xp[s])) begin
                errors++; $display("FAIL sticky_phase%0d sel=%b pulses=%0d exp %b %0d", s, sel1, pulses, xsel[s], xp[s]);
            end
        end
    endtask

    task automatic test_async_reset();
        int first = -1;
        btn_in = '0;
        repeat (12) step();
        btn_in = 4'b0001;
        repeat (5) step();
        #2 rst = 1'b1;
        #1 model_reset();
        checks++;
        if (w_obs !== '0) begin
            errors++; $display("FAIL arst_clear obs=%h exp=0", w_obs);
        end
        step(); step();
        rst = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step(); checks++;
            if (p0 === 1'b1 && first < 0) first = e;
            if (w_obs !== exp_vec()) begin
                errors++; $display("FAIL arst_requal obs=%h exp=%h", w_obs, exp_vec());
            end
        end
        checks++;
        if (first != 6) begin
            errors++; $display("FAIL arst_pulse_edge got=%0d exp=6", first);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int n = 0; n < 2500; n++) begin
            case ($urandom_range(0, 3))
                0: btn_in = '0;
                1: btn_in = NB'(1 << $urandom_range(0, NB - 1));
                2: btn_in = NB'($urandom);
                default: btn_in = btn_in ^ NB'(1 << $urandom_range(0, NB - 1));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                step();
                rst = 1'b0;
            end
            hold = $urandom_range(1, 8);
            repeat (hold) begin
                step(); checks++;
                if (w_obs !== exp_vec()) begin
                    errors++; $display("FAIL random n=%0d obs=%h exp=%h", n, w_obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_bounce();
        test_multi();
        test_sticky();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_sel_decoder.md
Name: btn_sel_decoder

Overview:
- Parametrised button-to-mux-select decoder for N push-buttons.
- Each raw input passes through a 2-flop synchroniser and a per-button debounce counter.
- The debounced vector is classified as none, exactly-one or multiple pressed, and drives a registered select code {1'b1, index} for the downstream display/mux selector.
- Adds what the combinational generation lacked: sticky/momentary mode, a press strobe and a multi-press error flag.

Parameters:
NUM_BTN, 4, number of button inputs (2..16)
DB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (>=2; 10 ms at 100 MHz)
STICKY, 0, 0 = select returns to 0 when released; 1 = last valid select held until a new valid press
IDX_W, $clog2(NUM_BTN), derived, index width
SEL_W, IDX_W+1, derived, select width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
btn_in  in  NUM_BTN  raw asynchronous buttons; bit i = button i (4-button board: [3]=U, [2]=D, [1]=R, [0]=L)
btn_db  out  NUM_BTN  debounced button levels
sel_out  out  SEL_W  registered select: {1'b1, idx} when a selection is active, else all zeros
sel_valid  out  1  high while sel_out is non-zero
press_pulse  out  1  one-cycle strobe when sel_out takes a new valid code
multi_err  out  1  high while more than one debounced button is pressed

Behaviour:
- Reset (async assert, sync release): sync flops, btn_db, counters = 0; FSM = IDLE; sel_out = 0, sel_valid = 0, press_pulse = 0, multi_err = 0.
- Synchroniser: s1 <= btn_in; s2 <= s1, per bit.
- Debounce, per bit i:
  - if s2[i] == btn_db[i], cnt[i] <= 0;
  - else if cnt[i] == DB_CYCLES-1, then btn_db[i] <= s2[i] and cnt[i] <= 0;
  - else cnt[i] <= cnt[i]+1.
  - Any glitch back to the old level restarts the count.
  - Counter width = $clog2(DB_CYCLES). Counters never wrap.
- Latency: a clean input edge sampled at rising edge 0 reaches s2 at edge 2. btn_db changes at edge DB_CYCLES+1. sel_out, sel_valid, multi_err and press_pulse change at edge DB_CYCLES+2.
- Classification is combinational on btn_db:
  - NONE: zero bits set.
  - ONE: exactly one bit set; idx = position of that bit.
  - MULTI: two or more bits set.
- FSM states and transitions (registered):
  - IDLE: ONE -> ACTIVE (load sel_out, pulse). MULTI -> BLOCKED.
  - ACTIVE: NONE -> IDLE. MULTI -> BLOCKED. ONE with a different idx -> ACTIVE (reload, pulse). Same idx -> stay, no pulse.
  - BLOCKED: NONE -> IDLE. ONE and MULTI -> stay BLOCKED. A press is only accepted after all buttons are released.
- Outputs by mode:
  - STICKY=0: sel_out = {1,idx} only in ACTIVE; 0 in IDLE and BLOCKED.
  - STICKY=1: sel_out keeps its last valid code in IDLE and BLOCKED; only a new ACTIVE load changes it. Before the first press, sel_out = 0.
  - sel_valid = |sel_out in both modes.
  - multi_err = 1 in BLOCKED, registered.
  - press_pulse is exactly one cycle per load and never high in consecutive cycles unless idx changes on consecutive cycles.
- Simultaneous debounce completion of two buttons in the same cycle is MULTI; no pulse.
- rst asserted mid-debounce or mid-press: everything clears immediately. After release, a still-held button must re-qualify through the full sync + DB_CYCLES path before any pulse.
- btn_in X/glitch shorter than DB_CYCLES cycles never changes btn_db.

Test Plan:
(Use DB_CYCLES=4, NUM_BTN=4.)
- Reset: rst=1 with btn_in=4'b1111 -> all outputs 0. Release rst and hold btn_in -> multi_err=1 at edge 6, sel_out stays 3'b000, no press_pulse.
- Single press, STICKY=0: btn_in=4'b0001 at edge 0 -> sel_out=3'b100, sel_valid=1, press_pulse=1 at edge 6 only. Release -> sel_out=3'b000 six edges later.
- Bounce: btn_in[2] toggles 1,0,1,0 every cycle for 8 cycles, then stays 1 -> btn_db[2] changes exactly once. sel_out=3'b110 with a single pulse.
- Multi-press lockout: press btn[3], then btn[1] while held -> sel_out 3'b111 then 3'b000, multi_err=1. Release btn[3] only -> remain blocked with sel_out=0. Release all, then press btn[1] -> sel_out=3'b101 with a pulse.
- STICKY=1: press/release btn[1] -> sel_out stays 3'b101 after release. Press btn[3] -> 3'b111 with a pulse. Re-press btn[3] after release -> no change, no pulse.
- Async reset mid-debounce: btn[0] high for 3 cycles of stable s2, then pulse rst -> cnt cleared, outputs 0. With btn[0] still held, pulse appears 6 edges after rst release.
